cpu_core_p: RTL and testbench

- Parametrised successor of the team's 8-bit teaching CPU.
- Configurable datapath width, register-file size, program address width and return-stack depth.
- New over the previous generation:
  - external instruction-fetch handshake; program memory is outside the block and may stall;
  - CALL/RET with a hardware return stack;
  - HLT instruction;
  - explicit Step control.
- Sits between the board I/O (Din/Sample, Dout/Dval, GPO, Debug) and an external program ROM/RAM.

---
 rtl/cpu_core_p.sv | 144 ++++++++++++++
 tb/tb_cpu_core_p.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised teaching CPU with external fetch handshake, return stack, HLT and Step control.
// Ports: Clock/Reset (sync, active-high); Step gates instruction start; Iaddr/Idata/Ivalid fetch
// from external program memory; Din/Sample load Reg[NREG-4]; Dout = Reg[NREG-2]; Dval/GPO split
// Reg[NREG-3]; Halted in HALT state; Debug = {SHFT, OFLW, SMPL, executing}.
module cpu_core_p #(
  parameter int DW = 8,
  parameter int NREG = 32,
  parameter int AW = 8,
  parameter int SDEPTH = 4,
  localparam int IW = 11 + 2 * DW + AW
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Step,
  output logic [AW-1:0] Iaddr,
  input  logic [IW-1:0] Idata,
  input  logic          Ivalid,
  input  logic [DW-1:0] Din,
  input  logic          Sample,
  output logic [DW-1:0] Dout,
  output logic          Dval,
  output logic [DW-2:0] GPO,
  output logic          Halted,
  output logic [3:0]    Debug
);
  localparam int RAW = $clog2(NREG);
  localparam int SW = $clog2(SDEPTH + 1);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t state, state_nx;
  logic [DW-1:0] regs [NREG];
  logic [AW-1:0] stack [2**SW];
  logic [SW-1:0] sp;
  logic [IW-1:0] ir;
  logic [AW-1:0] ip, ip_nx, ip_inc, addr;
  logic [3:0] grp;
  logic [2:0] cmd;
  logic [1:0] t1, t2;
  logic [DW-1:0] a1, a2, op1, op2, flags, flags_nx, wr_val, mov_r, acc_r, fm, fv;
  logic [RAW-1:0] p1, p2, l1, l2, wr_idx;
  logic [DW:0] usum, ssum;
  logic [2*DW-1:0] uprod, sprod;
  logic [7:0] cv, f8;
  logic is_exec, wr_en, acc_ovf, sovf, eq, slt, full, empty;
  assign {grp, cmd, t1, a1, t2, a2, addr} = ir;
  assign flags = regs[NREG-1];
  assign f8 = 8'(flags);
  assign is_exec = state == EXEC;
  assign full = sp == SW'(SDEPTH);
  assign empty = sp == '0;
  assign ip_inc = ip + 1'b1;
  // Operand decode: REG and IND share the final register read, IND adds one pointer hop.
  always_comb begin
    p1 = RAW'(a1);
    p2 = RAW'(a2);
    l1 = t1 == 2'd2 ? RAW'(regs[p1]) : p1;
    l2 = t2 == 2'd2 ? RAW'(regs[p2]) : p2;
    op1 = (t1 == 2'd1 || t1 == 2'd2) ? regs[l1] : a1;
    op2 = (t2 == 2'd1 || t2 == 2'd2) ? regs[l2] : a2;
  end
  // Signed results come from sign-extended operands; the low bits of an unsigned op are exact.
  always_comb begin
    usum = {1'b0, op1} + {1'b0, op2};
    ssum = {op1[DW-1], op1} + {op2[DW-1], op2};
    uprod = {{DW{1'b0}}, op1} * {{DW{1'b0}}, op2};
    sprod = {{DW{op1[DW-1]}}, op1} * {{DW{op2[DW-1]}}, op2};
    sovf = ~(&sprod[2*DW-1:DW-1] | ~|sprod[2*DW-1:DW-1]);
    eq = op1 == op2;
    slt = $signed(op1) < $signed(op2);
    cv = {2'b00, slt | eq, op1 <= op2, slt, op1 < op2, eq, 1'b1};
    mov_r = cmd == 3'd1 ? {op1[DW-2:0], 1'b0} : cmd == 3'd2 ? {1'b0, op1[DW-1:1]} : op1;
    acc_r = cmd == 3'd0 ? usum[DW-1:0] : cmd == 3'd1 ? ssum[DW-1:0] :
            cmd == 3'd2 ? uprod[DW-1:0] : cmd == 3'd3 ? sprod[DW-1:0] :
            cmd == 3'd4 ? op1 & op2 : cmd == 3'd5 ? op1 | op2 : op1 ^ op2;
    acc_ovf = cmd == 3'd0 ? usum[DW] : cmd == 3'd1 ? ssum[DW] ^ ssum[DW-1] :
              cmd == 3'd2 ? |uprod[2*DW-1:DW] : sovf;
  end
  always_comb begin
    wr_en = is_exec && (grp == 4'd0 ? (t2 == 2'd1 || t2 == 2'd2) :
                        grp == 4'd1 ? ((t1 == 2'd1 || t1 == 2'd2) && cmd != 3'd7) : 1'b0);
    wr_idx = grp == 4'd0 ? l2 : l1;
    wr_val = grp == 4'd0 ? mov_r : acc_r;
    fm = '0;
    fv = '0;
    if (grp == 4'd0 && (cmd == 3'd1 || cmd == 3'd2)) begin
      fm[0] = 1'b1;
      fv[0] = cmd == 3'd1 ? op1[DW-1] : op1[0];
    end
    if (grp == 4'd1 && cmd < 3'd4) begin
      fm[1] = 1'b1;
      fv[1] = acc_ovf;
    end
    if (grp == 4'd3) fm = DW'(1) << cmd;
    if ((grp == 4'd4 && full) || (grp == 4'd5 && empty)) begin
      fm[3] = 1'b1;
      fv[3] = 1'b1;
    end
    // Hardware flag updates override an instruction write to the flags register bit by bit.
    flags_nx = (((wr_en && wr_idx == RAW'(NREG - 1)) ? wr_val : flags) & ~fm) | fv;
    ip_nx = grp == 4'd2 ? (cv[cmd] ? addr : ip_inc) :
            grp == 4'd3 ? (f8[cmd] ? addr : ip_inc) :
            grp == 4'd4 ? (full ? ip_inc : addr) :
            grp == 4'd5 ? (empty ? ip_inc : stack[sp - 1'b1]) :
            grp == 4'd6 ? ip : ip_inc;
  end
  always_ff @(posedge Clock)
    if (Reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (Step ? FETCH : IDLE) :
               state == FETCH ? (Ivalid ? EXEC : FETCH) :
               state == EXEC ? (grp == 4'd6 ? HALT : IDLE) : HALT;
  always_comb begin
    Iaddr = ip;
    Dout = regs[NREG-2];
    Dval = regs[NREG-3][DW-1];
    GPO = regs[NREG-3][DW-2:0];
    Halted = state == HALT;
    Debug = {flags[0], flags[1], flags[2], is_exec};
  end
  // Later non-blocking writes win: Sample is applied after the instruction commit.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ip <= '0;
      sp <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (state == FETCH && Ivalid) ir <= Idata;
      if (is_exec) begin
        ip <= ip_nx;
        if (wr_en) regs[wr_idx] <= wr_val;
        regs[NREG-1] <= flags_nx;
        if (grp == 4'd4 && !full) begin
          stack[sp] <= ip_inc;
          sp <= sp + 1'b1;
        end
        if (grp == 4'd5 && !empty) sp <= sp - 1'b1;
      end
      if (Sample) begin
        regs[NREG-4] <= Din;
        regs[NREG-1][2] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cpu_core_p.sv
// tb_cpu_core_p: directed programs with an instruction-level reference model checked every cycle.
module tb_cpu_core_p;
  localparam int DW = 8, AW = 8, SD = 2, IW = 11 + 2 * DW + AW;
  logic Clock = 0, Reset = 1, Step = 1, Ivalid = 1, Sample = 0;
  logic [DW-1:0] Din = 0;
  logic [AW-1:0] Iaddr;
  logic [IW-1:0] Idata;
  logic [DW-1:0] Dout;
  logic Dval, Halted;
  logic [DW-2:0] GPO;
  logic [3:0] Debug;
  logic [IW-1:0] rom [256];
  int checks = 0, errors = 0;
  int m_reg [32];
  int m_ip = 0, m_phase = 0;
  int m_stk [$];
  logic [IW-1:0] m_ir;
  bit armed = 0;

  cpu_core_p #(.DW(DW), .NREG(32), .AW(AW), .SDEPTH(SD)) dut (
    .Clock(Clock), .Reset(Reset), .Step(Step), .Iaddr(Iaddr), .Idata(Idata), .Ivalid(Ivalid),
    .Din(Din), .Sample(Sample), .Dout(Dout), .Dval(Dval), .GPO(GPO), .Halted(Halted), .Debug(Debug));

  assign Idata = rom[Iaddr];
  always #5 Clock = ~Clock;

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] ins(int g, int c, int t1, int a1, int t2, int a2, int ad);
    return {4'(g), 3'(c), 2'(t1), 8'(a1), 2'(t2), 8'(a2), 8'(ad)};
  endfunction

  function automatic int opnd(int t, int a);
    return t == 1 ? m_reg[a % 32] : t == 2 ? m_reg[m_reg[a % 32] % 32] : a;
  endfunction

  function automatic int loc(int t, int a);
    return t == 1 ? a % 32 : t == 2 ? m_reg[a % 32] % 32 : -1;
  endfunction

  function automatic void setflag(int b, int v);
    m_reg[31] = (m_reg[31] & ~(1 << b) & 255) | ((v & 1) << b);
  endfunction

  task automatic m_exec();
    int g, c, t1, a1, t2, a2, ad, x, y, sx, sy, r, d, of, nip;
    bit cond;
    g = int'(m_ir[34:31]); c = int'(m_ir[30:28]); t1 = int'(m_ir[27:26]); a1 = int'(m_ir[25:18]);
    t2 = int'(m_ir[17:16]); a2 = int'(m_ir[15:8]); ad = int'(m_ir[7:0]);
    nip = (m_ip + 1) % 256;
    m_phase = 0;
    x = opnd(t1, a1); y = opnd(t2, a2);
    sx = x > 127 ? x - 256 : x; sy = y > 127 ? y - 256 : y;
    r = 0; of = 0;
    if (g == 0) begin
      r = c == 1 ? (x * 2) % 256 : c == 2 ? x / 2 : x;
      d = loc(t2, a2);
      if (d >= 0) m_reg[d] = r;
      if (c == 1) setflag(0, x / 128);
      if (c == 2) setflag(0, x % 2);
    end else if (g == 1) begin
      d = loc(t1, a1);
      if (c == 0) begin r = x + y; of = int'(r > 255); end
      if (c == 1) begin r = sx + sy; of = int'(r < -128 || r > 127); end
      if (c == 2) begin r = x * y; of = int'(r > 255); end
      if (c == 3) begin r = sx * sy; of = int'(r < -128 || r > 127); end
      if (c == 4) r = x & y;
      if (c == 5) r = x | y;
      if (c == 6) r = x ^ y;
      if (c != 7 && d >= 0) m_reg[d] = r & 255;
      if (c < 4) setflag(1, of);
    end else if (g == 2) begin
      cond = c == 0 || (c == 1 && x == y) || (c == 2 && x < y) || (c == 3 && sx < sy) ||
             (c == 4 && x <= y) || (c == 5 && sx <= sy);
      if (cond) nip = ad;
    end else if (g == 3) begin
      if ((m_reg[31] >> c) & 1) nip = ad;
      setflag(c, 0);
    end else if (g == 4) begin
      if (m_stk.size() == SD) setflag(3, 1);
      else begin m_stk.push_back(nip); nip = ad; end
    end else if (g == 5) begin
      if (m_stk.size() == 0) setflag(3, 1);
      else nip = m_stk.pop_back();
    end else if (g == 6) begin
      nip = m_ip;
      m_phase = 3;
    end
    m_ip = nip;
  endtask

  // Reference model: phases 0 idle, 1 waiting for fetch, 2 executing, 3 halted.
  always @(posedge Clock) begin
    if (Reset) begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_ip = 0; m_phase = 0; m_stk.delete(); armed = 1;
    end else begin
      if (m_phase == 2) m_exec();
      else if (m_phase == 0 && Step) m_phase = 1;
      else if (m_phase == 1 && Ivalid) begin m_ir = rom[m_ip]; m_phase = 2; end
      if (Sample) begin m_reg[28] = int'(Din); setflag(2, 1); end
    end
  end

  always @(posedge Clock) begin
    #1;
    if (armed) begin
      check("iaddr", Iaddr, m_ip);
      check("dout", Dout, m_reg[30]);
      check("dval", Dval, (m_reg[29] >> 7) & 1);
      check("gpo", GPO, m_reg[29] & 127);
      check("halted", Halted, m_phase == 3);
      check("debug", Debug, ((m_reg[31] & 1) << 3) | (((m_reg[31] >> 1) & 1) << 2) |
                            (((m_reg[31] >> 2) & 1) << 1) | int'(m_phase == 2));
    end
  end

  task automatic begin_prog();
    @(negedge Clock);
    Reset = 1; Step = 1; Ivalid = 1; Sample = 0;
    foreach (rom[i]) rom[i] = ins(7, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic end_prog();
    @(negedge Clock);
    Reset = 0;
  endtask

  task automatic run_instr(int k);
    repeat (3 * k) @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    begin_prog();
    rom[0] = ins(0, 0, 0, 8'h81, 1, 29, 0);
    rom[1] = ins(0, 0, 0, 8'h5A, 1, 30, 0);
    rom[2] = ins(2, 0, 0, 0, 0, 0, 2);
    end_prog();
    run_instr(2);
    check("lit_dout_5a", Dout, 8'h5A);
    check("lit_dval", Dval, 1);
    check("lit_gpo", GPO, 1);
    check("lit_not_halted", Halted, 0);

    begin_prog();
    rom[0] = ins(0, 0, 0, 200, 1, 0, 0);
    rom[1] = ins(1, 0, 1, 0, 0, 100, 0);
    rom[2] = ins(0, 0, 1, 0, 1, 30, 0);
    rom[3] = ins(0, 0, 0, 100, 1, 1, 0);
    rom[4] = ins(1, 1, 1, 1, 0, 50, 0);
    rom[5] = ins(0, 0, 1, 1, 1, 30, 0);
    rom[6] = ins(0, 0, 0, 8'hFE, 1, 2, 0);
    rom[7] = ins(1, 3, 1, 2, 0, 3, 0);
    rom[8] = ins(0, 0, 1, 2, 1, 30, 0);
    rom[9] = ins(0, 1, 1, 2, 1, 3, 0);
    rom[10] = ins(2, 3, 1, 2, 0, 1, 12);
    rom[11] = ins(0, 0, 0, 8'hEE, 1, 30, 0);
    rom[12] = ins(0, 0, 0, 3, 1, 4, 0);
    rom[13] = ins(0, 0, 2, 4, 1, 30, 0);
    rom[14] = ins(2, 0, 0, 0, 0, 0, 14);
    end_prog();
    run_instr(3);
    check("lit_uad", Dout, 44);
    check("lit_uad_oflw", Debug[2], 1);
    check("model_r0", m_reg[0], 44);
    run_instr(3);
    check("lit_sad", Dout, 8'h96);
    check("lit_sad_oflw", Debug[2], 1);
    run_instr(3);
    check("lit_smt", Dout, 8'hFA);
    check("lit_smt_oflw", Debug[2], 0);
    run_instr(4);
    check("lit_shl_ind", Dout, 8'hF4);
    check("lit_shft", Debug[3], 1);

    begin_prog();
    rom[0] = ins(0, 0, 0, 8'h11, 1, 30, 0);
    rom[1] = ins(0, 0, 0, 8'h22, 1, 30, 0);
    rom[2] = ins(2, 0, 0, 0, 0, 0, 2);
    Ivalid = 0;
    end_prog();
    repeat (5) begin
      @(negedge Clock);
      check("stall_iaddr", Iaddr, 0);
      check("stall_dout", Dout, 0);
    end
    Ivalid = 1;
    @(negedge Clock);
    check("lit_exec_after_valid", Debug[0], 1);
    @(negedge Clock);
    check("lit_stall_commit", Dout, 8'h11);
    check("lit_stall_ip", Iaddr, 1);
    Ivalid = 0;
    @(negedge Clock);
    Reset = 1; Ivalid = 1;
    @(negedge Clock);
    Reset = 0; Ivalid = 0;
    check("lit_rst_ip", Iaddr, 0);
    check("lit_rst_dout", Dout, 0);
    check("lit_rst_idle", Debug[0], 0);
    @(negedge Clock);
    check("lit_rst_hold", Iaddr, 0);

    begin_prog();
    rom[0] = ins(2, 0, 0, 0, 0, 0, 3);
    rom[3] = ins(4, 0, 0, 0, 0, 0, 10);
    rom[10] = ins(4, 0, 0, 0, 0, 0, 20);
    rom[20] = ins(4, 0, 0, 0, 0, 0, 30);
    rom[21] = ins(5, 0, 0, 0, 0, 0, 0);
    rom[11] = ins(5, 0, 0, 0, 0, 0, 0);
    rom[4] = ins(5, 0, 0, 0, 0, 0, 0);
    rom[5] = ins(0, 0, 1, 31, 1, 30, 0);
    rom[6] = ins(2, 0, 0, 0, 0, 0, 6);
    end_prog();
    run_instr(4);
    check("lit_call_full", Iaddr, 21);
    run_instr(1);
    check("lit_ret1", Iaddr, 11);
    run_instr(1);
    check("lit_ret2", Iaddr, 4);
    run_instr(1);
    check("lit_ret_empty", Iaddr, 5);
    run_instr(1);
    check("lit_stke", Dout, 8'h08);

    begin_prog();
    rom[0] = ins(0, 0, 0, 0, 1, 28, 0);
    rom[1] = ins(0, 0, 1, 28, 1, 30, 0);
    rom[2] = ins(3, 2, 0, 0, 0, 0, 40);
    rom[40] = ins(0, 0, 1, 31, 1, 30, 0);
    rom[41] = ins(2, 0, 0, 0, 0, 0, 41);
    end_prog();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Sample = 1; Din = 8'h7F;
    @(negedge Clock);
    Sample = 0;
    check("lit_smpl_set", Debug[1], 1);
    run_instr(1);
    check("lit_sample_wins", Dout, 8'h7F);
    run_instr(1);
    check("lit_atc_jump", Iaddr, 40);
    check("lit_smpl_clr", Debug[1], 0);
    run_instr(1);
    check("lit_flags_zero", Dout, 0);

    begin_prog();
    rom[0] = ins(2, 0, 0, 0, 0, 0, 5);
    rom[5] = ins(6, 0, 0, 0, 0, 0, 0);
    end_prog();
    run_instr(2);
    check("lit_halted", Halted, 1);
    Sample = 1; Din = 8'h33;
    @(negedge Clock);
    Sample = 0;
    repeat (20) begin
      @(negedge Clock);
      check("lit_halt_iaddr", Iaddr, 5);
    end
    check("lit_halt_smpl", Debug[1], 1);
    Reset = 1;
    @(negedge Clock);
    Reset = 0;
    check("lit_unhalt", Halted, 0);
    check("lit_unhalt_ip", Iaddr, 0);
    repeat (3) @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
